dcache_direct: RTL

DCACHE_DIRECT -- requirements
Module: dcache_direct

---
 rtl/dcache_direct.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/dcache_direct.sv
// -----------------------------------------------------------------------------
// dcache_direct
//   Direct-mapped, write-through, no-write-allocate data cache with 32-bit words
//   and single-word-per-beat line refill from the memory side.
//
//   Address split (byte address):
//     [1:0]                              byte offset
//     next log2(LINE_WORDS) bits         word within the line
//     next log2(SET_NUM) bits            line index
//     remaining upper bits               tag
//
//   Optional feature:
//     DCACHE_STATS_EN  when defined, stat_hit_o/stat_miss_o count read/write
//                      hits and misses, saturating at 0xFFFFFFFF. When
//                      undefined, both ports are tied to 0.
//
//   Ports:
//     clk, rst                 clock (rising edge), asynchronous active-low reset
//     dcache_rreq_i/_wreq_i    CPU read / write request (read wins when both set)
//     dcache_addr_i            CPU byte address
//     dcache_wdata_i/_sel_i    CPU write data and byte enables
//     dcache_data_o            read data, qualified by dcache_rvalid_o
//     dcache_rvalid_o          one-cycle read-data pulse
//     dcache_stall_o           cache busy with a refill or a memory write
//     mem_rreq_o/mem_wreq_o    memory read / write request
//     mem_addr_o               memory word address (bits [1:0] always 0)
//     mem_wdata_o/mem_sel_o    memory write data and byte enables
//     mem_rdata_i/mem_rvalid_i memory read data, one word per beat
//     mem_wack_i               memory write accepted
//     stat_hit_o/stat_miss_o   hit and miss counters
//
//   Handshakes: the CPU side presents a request for a cycle while the cache is
//   idle and not stalled; the request is accepted on that rising edge. On the
//   memory side a request stays asserted with stable address/data/sel until the
//   matching mem_rvalid_i beat (reads) or mem_wack_i (writes) is seen on a
//   rising edge; responses outside the matching state are ignored.
// -----------------------------------------------------------------------------
module dcache_direct #(
  parameter int SET_NUM    = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dcache_rreq_i,
  input  logic        dcache_wreq_i,
  input  logic [31:0] dcache_addr_i,
  input  logic [31:0] dcache_wdata_i,
  input  logic [3:0]  dcache_sel_i,
  output logic [31:0] dcache_data_o,
  output logic        dcache_rvalid_o,
  output logic        dcache_stall_o,
  output logic        mem_rreq_o,
  output logic        mem_wreq_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_sel_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_wack_i,
  output logic [31:0] stat_hit_o,
  output logic [31:0] stat_miss_o
);

  localparam int OFS_W      = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(SET_NUM);
  localparam int TAG_W      = 30 - OFS_W - IDX_W;
  localparam int BEAT_W     = (OFS_W > 0) ? OFS_W : 1;
  localparam int DA_W       = OFS_W + IDX_W;
  localparam int LINE_SHIFT = 2 + OFS_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

  state_t state_q, state_d;

  // Storage: data words are not reset; only the valid bits are.
  logic [31:0]       data_mem [SET_NUM*LINE_WORDS];
  logic [TAG_W-1:0]  tag_mem  [SET_NUM];
  logic [SET_NUM-1:0] valid_q;

  logic [31:0]       req_addr_q;
  logic [31:0]       req_wdata_q;
  logic [3:0]        req_sel_q;
  logic [BEAT_W-1:0] beat_q;
  logic [31:0]       rdata_q;
  logic              hit_rvalid_q;

  function automatic logic [IDX_W-1:0] f_idx(input logic [31:0] a);
    return IDX_W'(a >> LINE_SHIFT);
  endfunction

  function automatic logic [BEAT_W-1:0] f_word(input logic [31:0] a);
    return BEAT_W'((a >> 2) & 32'(LINE_WORDS - 1));
  endfunction

  function automatic logic [TAG_W-1:0] f_tag(input logic [31:0] a);
    return a[31 -: TAG_W];
  endfunction

  function automatic logic [DA_W-1:0] f_da(input logic [IDX_W-1:0] idx,
                                           input logic [BEAT_W-1:0] word);
    return DA_W'(idx) * DA_W'(LINE_WORDS) + DA_W'(word);
  endfunction

  // Lookup on the incoming CPU address
  logic [IDX_W-1:0]  idx_in;
  logic [DA_W-1:0]   da_in;
  logic              hit;
  logic              accept;
  logic              is_read;

  assign idx_in  = f_idx(dcache_addr_i);
  assign da_in   = f_da(idx_in, f_word(dcache_addr_i));
  assign hit     = valid_q[idx_in] && (tag_mem[idx_in] == f_tag(dcache_addr_i));
  assign accept  = (state_q == IDLE) && (dcache_rreq_i || dcache_wreq_i);
  assign is_read = dcache_rreq_i;  // read has priority; a simultaneous write is dropped

  // Request held for the refill / memory write
  logic [IDX_W-1:0]  req_idx;
  logic [BEAT_W-1:0] req_word;
  logic [31:0]       line_base;

  assign req_idx   = f_idx(req_addr_q);
  assign req_word  = f_word(req_addr_q);
  assign line_base = (req_addr_q >> LINE_SHIFT) << LINE_SHIFT;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and memory-side / stall outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    dcache_stall_o = 1'b0;
    mem_rreq_o     = 1'b0;
    mem_wreq_o     = 1'b0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    mem_sel_o      = '0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_read)  state_d = WRITE;
          else if (!hit) state_d = REFILL;
        end
      end
      REFILL: begin
        dcache_stall_o = 1'b1;
        mem_rreq_o     = 1'b1;
        mem_addr_o     = line_base | (32'(beat_q) << 2);
        if (mem_rvalid_i && (beat_q == LAST_BEAT)) state_d = RESP;
      end
      WRITE: begin
        dcache_stall_o = 1'b1;
        mem_wreq_o     = 1'b1;
        mem_addr_o     = {req_addr_q[31:2], 2'b00};
        mem_wdata_o    = req_wdata_q;
        mem_sel_o      = req_sel_q;
        if (mem_wack_i) state_d = IDLE;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control datapath: request capture, valid bits, beat counter, read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= '0;
      beat_q       <= '0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_sel_q    <= '0;
      rdata_q      <= '0;
      hit_rvalid_q <= 1'b0;
    end else begin
      hit_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_addr_q <= dcache_addr_i;
            if (is_read) begin
              if (hit) begin
                rdata_q      <= data_mem[da_in];
                hit_rvalid_q <= 1'b1;
              end else begin
                // The line is rewritten word by word; keep it invalid until
                // the last beat so an interrupted refill never looks valid.
                valid_q[idx_in] <= 1'b0;
                beat_q          <= '0;
              end
            end else begin
              req_wdata_q <= dcache_wdata_i;
              req_sel_q   <= dcache_sel_i;
            end
          end
        end
        REFILL: begin
          if (mem_rvalid_i) begin
            if (beat_q == req_word) rdata_q <= mem_rdata_i;
            if (beat_q == LAST_BEAT) begin
              beat_q           <= '0;
              valid_q[req_idx] <= 1'b1;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data and tag arrays (no reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept && !is_read && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (dcache_sel_i[b]) data_mem[da_in][8*b +: 8] <= dcache_wdata_i[8*b +: 8];
      end
    end
    if ((state_q == REFILL) && mem_rvalid_i) begin
      data_mem[f_da(req_idx, beat_q)] <= mem_rdata_i;
      if (beat_q == LAST_BEAT) tag_mem[req_idx] <= f_tag(req_addr_q);
    end
  end

  assign dcache_data_o   = rdata_q;
  assign dcache_rvalid_o = hit_rvalid_q || (state_q == RESP);

  // ---------------------------------------------------------------------------
  // Hit / miss statistics
  // ---------------------------------------------------------------------------
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign stat_hit_o  = hit_cnt_q;
  assign stat_miss_o = miss_cnt_q;
`else
  assign stat_hit_o  = '0;
  assign stat_miss_o = '0;
`endif

endmodule
